// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//
// Multi-cycle command sequencer in front of the register-file/ALU datapath.
// Accepts one command at a time over a valid/ready handshake and drives the
// datapath addresses, ALU function, write data and write enable. Supports
// LOADI (immediate write), ALU (dst <= src1 op src2) and REPEAT
// (dst <= dst op src2, cmd_count times). Reports completion with a one-cycle
// done pulse and keeps the zero status of the most recent register write.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake
//   cmd_op                  00 NOP, 01 LOADI, 10 ALU, 11 REPEAT
//   cmd_alufn               ALU function code forwarded to the datapath
//   cmd_dst/src1/src2       register addresses (AW bits)
//   cmd_imm                 immediate for LOADI (Dbits)
//   cmd_count               REPEAT iteration count (0-15)
//   RegWrite                datapath write enable
//   ReadAddr1/2, WriteAddr  datapath register addresses
//   ALUFN                   datapath ALU function
//   WriteData               datapath write data
//   ALUResult, FlagZ        combinational result and zero flag from datapath
//   busy                    command in progress
//   done                    one-cycle pulse at command completion
//   zero_flag               zero status of the most recent register write
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// EXEC  | driving datapath writes (one for LOADI/ALU, N for REPEAT)
// DONE  | done pulse, returns to IDLE on the next edge

module datapath_sequencer #(
    parameter  int Nloc  = 32,
    parameter  int Dbits = 8,
    localparam int AW    = $clog2(Nloc)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [4:0]       cmd_alufn,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src1,
    input  logic [AW-1:0]    cmd_src2,
    input  logic [Dbits-1:0] cmd_imm,
    input  logic [3:0]       cmd_count,

    output logic             RegWrite,
    output logic [AW-1:0]    ReadAddr1,
    output logic [AW-1:0]    ReadAddr2,
    output logic [AW-1:0]    WriteAddr,
    output logic [4:0]       ALUFN,
    output logic [Dbits-1:0] WriteData,
    input  logic [Dbits-1:0] ALUResult,
    input  logic             FlagZ,

    output logic             busy,
    output logic             done,
    output logic             zero_flag
);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_LOADI  = 2'b01;
    localparam logic [1:0] OP_ALU    = 2'b10;
    localparam logic [1:0] OP_REPEAT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]       lat_op;
    logic [4:0]       lat_alufn;
    logic [AW-1:0]    lat_dst;
    logic [AW-1:0]    lat_src1;
    logic [AW-1:0]    lat_src2;
    logic [Dbits-1:0] lat_imm;
    logic [3:0]       remaining;
    logic             zero_reg;

    logic accept;
    logic skip_exec;

    // Handshake only completes while out of reset and idle; cmd_ready is
    // gated by reset so a command can never be taken on a reset edge.
    assign accept    = cmd_valid && cmd_ready;

    // NOP and a zero-count REPEAT have nothing to write, so they bypass EXEC.
    assign skip_exec = (cmd_op == OP_NOP) ||
                       ((cmd_op == OP_REPEAT) && (cmd_count == 4'd0));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = skip_exec ? DONE : EXEC;
                end
            end
            EXEC: begin
                // REPEAT stays while more than one iteration is left; the
                // cycle with remaining == 1 performs the final write.
                if ((lat_op == OP_REPEAT) && (remaining > 4'd1)) begin
                    next_state = EXEC;
                end else begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, iteration counter and zero flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_op    <= '0;
            lat_alufn <= '0;
            lat_dst   <= '0;
            lat_src1  <= '0;
            lat_src2  <= '0;
            lat_imm   <= '0;
            remaining <= '0;
            zero_reg  <= 1'b0;
        end else begin
            if (accept) begin
                lat_op    <= cmd_op;
                lat_alufn <= cmd_alufn;
                lat_dst   <= cmd_dst;
                lat_src1  <= cmd_src1;
                lat_src2  <= cmd_src2;
                lat_imm   <= cmd_imm;
                remaining <= cmd_count;
            end
            if (state == EXEC) begin
                case (lat_op)
                    OP_LOADI: zero_reg <= (lat_imm == '0);
                    OP_ALU:   zero_reg <= FlagZ;
                    OP_REPEAT: begin
                        zero_reg  <= FlagZ;
                        remaining <= remaining - 4'd1;
                    end
                    default: zero_reg <= zero_reg;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        RegWrite  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        WriteData = ALUResult;
        ALUFN     = lat_alufn;
        WriteAddr = lat_dst;
        ReadAddr2 = lat_src2;
        // REPEAT reads its own destination so each pass accumulates in place.
        ReadAddr1 = (lat_op == OP_REPEAT) ? lat_dst : lat_src1;

        case (state)
            IDLE: cmd_ready = !reset;
            EXEC: begin
                busy     = !reset;
                RegWrite = !reset;
                if (lat_op == OP_LOADI) begin
                    WriteData = lat_imm;
                end
            end
            DONE: begin
                busy = !reset;
                done = !reset;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign zero_flag = zero_reg;

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

    localparam int AW = 5;
    localparam int DB = 8;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [4:0]    cmd_alufn;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_src1;
    logic [AW-1:0] cmd_src2;
    logic [DB-1:0] cmd_imm;
    logic [3:0]    cmd_count;
    logic          RegWrite;
    logic [AW-1:0] ReadAddr1;
    logic [AW-1:0] ReadAddr2;
    logic [AW-1:0] WriteAddr;
    logic [4:0]    ALUFN;
    logic [DB-1:0] WriteData;
    logic [DB-1:0] ALUResult;
    logic          FlagZ;
    logic          busy;
    logic          done;
    logic          zero_flag;

    datapath_sequencer #(.Nloc(32), .Dbits(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_alufn (cmd_alufn),
        .cmd_dst   (cmd_dst),
        .cmd_src1  (cmd_src1),
        .cmd_src2  (cmd_src2),
        .cmd_imm   (cmd_imm),
        .cmd_count (cmd_count),
        .RegWrite  (RegWrite),
        .ReadAddr1 (ReadAddr1),
        .ReadAddr2 (ReadAddr2),
        .WriteAddr (WriteAddr),
        .ALUFN     (ALUFN),
        .WriteData (WriteData),
        .ALUResult (ALUResult),
        .FlagZ     (FlagZ),
        .busy      (busy),
        .done      (done),
        .zero_flag (zero_flag)
    );

    localparam logic [1:0] NOP = 2'b00, LOADI = 2'b01, ALU = 2'b10, REPEAT = 2'b11;
    localparam logic [4:0] FN_ADD = 5'd0, FN_SUB = 5'd1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural datapath: combinational read + ALU, write on the rising edge.
    logic [DB-1:0] regs [32];
    int wr_cnt   = 0;
    int done_cnt = 0;

    always_comb begin
        case (ALUFN)
            FN_ADD:  ALUResult = regs[ReadAddr1] + regs[ReadAddr2];
            FN_SUB:  ALUResult = regs[ReadAddr1] - regs[ReadAddr2];
            default: ALUResult = regs[ReadAddr1] & regs[ReadAddr2];
        endcase
        FlagZ = (ALUResult == '0);
    end

    always @(posedge clock) begin
        if (RegWrite) begin
            regs[WriteAddr] <= WriteData;
            wr_cnt          <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wr0, dn0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents a command at a falling edge once the sequencer is ready and
    // returns #1 after the accepting rising edge with cmd_valid dropped.
    task automatic issue(input logic [1:0] op, input logic [4:0] fn,
                         input logic [AW-1:0] dst, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic [DB-1:0] imm,
                         input logic [3:0] cnt);
        int i;
        @(negedge clock);
        for (i = 0; i < 50 && !cmd_ready; i++) @(negedge clock);
        if (i >= 50) chk("ready_timeout", 32'(i), 32'(0));
        wr0 = wr_cnt;
        dn0 = done_cnt;
        cmd_op = op; cmd_alufn = fn; cmd_dst = dst; cmd_src1 = s1;
        cmd_src2 = s2; cmd_imm = imm; cmd_count = cnt;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for done, steps past it, and reports latency/write/done counts.
    task automatic finish_cmd(output int lat, output int writes, output int dones);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (lat >= 40) chk("done_timeout", 32'(lat), 32'(0));
        @(posedge clock);
        #1;
        writes = wr_cnt - wr0;
        dones  = done_cnt - dn0;
        chk("done_cleared", 32'(done), 32'(0));
        chk("ready_back", 32'(cmd_ready), 32'(1));
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [4:0] fn,
                       input logic [AW-1:0] dst, input logic [AW-1:0] s1,
                       input logic [AW-1:0] s2, input logic [DB-1:0] imm,
                       input logic [3:0] cnt, input int exp_lat, input int exp_wr);
        int lat, w, d;
        issue(op, fn, dst, s1, s2, imm, cnt);
        finish_cmd(lat, w, d);
        chk({tag, "_lat"},    32'(lat), 32'(exp_lat));
        chk({tag, "_writes"}, 32'(w),   32'(exp_wr));
        chk({tag, "_dones"},  32'(d),   32'(1));
    endtask

    initial begin
        int lat, w, d, gap;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_alufn = '0;
        cmd_dst = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_imm = '0; cmd_count = '0;

        // Reset phase: outputs gated while reset is high.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'(0));
        chk("rst_busy",  32'(busy),      32'(0));
        chk("rst_wr",    32'(RegWrite),  32'(0));
        chk("rst_done",  32'(done),      32'(0));
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("idle_ready", 32'(cmd_ready), 32'(1));
            chk("idle_wr",    32'(RegWrite),  32'(0));
            chk("idle_done",  32'(done),      32'(0));
            chk("idle_zf",    32'(zero_flag), 32'(0));
        end

        // LOADI r3 = 0x2A with exact cycle-level output checks.
        issue(LOADI, 5'd0, 5'd3, 5'd0, 5'd0, 8'h2A, 4'd0);
        chk("ldi_wr",    32'(RegWrite),  32'(1));
        chk("ldi_waddr", 32'(WriteAddr), 32'(3));
        chk("ldi_wdata", 32'(WriteData), 32'h2A);
        chk("ldi_busy",  32'(busy),      32'(1));
        chk("ldi_ready", 32'(cmd_ready), 32'(0));
        finish_cmd(lat, w, d);
        chk("ldi_lat",    32'(lat),     32'(1));
        chk("ldi_writes", 32'(w),       32'(1));
        chk("ldi_dones",  32'(d),       32'(1));
        chk("ldi_r3",     32'(regs[3]), 32'h2A);
        chk("ldi_zf",     32'(zero_flag), 32'(0));

        run("ldi0", LOADI, 5'd0, 5'd8, 5'd0, 5'd0, 8'h00, 4'd0, 1, 1);
        chk("ldi0_zf", 32'(zero_flag), 32'(1));
        chk("ldi0_r8", 32'(regs[8]),   32'(0));

        // ALU ADD r4 = r1 + r2.
        run("ldr1", LOADI, 5'd0, 5'd1, 5'd0, 5'd0, 8'd5, 4'd0, 1, 1);
        run("ldr2", LOADI, 5'd0, 5'd2, 5'd0, 5'd0, 8'd7, 4'd0, 1, 1);
        issue(ALU, FN_ADD, 5'd4, 5'd1, 5'd2, 8'hFF, 4'd0);
        chk("add_ra1",   32'(ReadAddr1), 32'(1));
        chk("add_ra2",   32'(ReadAddr2), 32'(2));
        chk("add_wa",    32'(WriteAddr), 32'(4));
        chk("add_fn",    32'(ALUFN),     32'(FN_ADD));
        chk("add_wdata", 32'(WriteData), 32'(12));
        finish_cmd(lat, w, d);
        chk("add_lat", 32'(lat),     32'(1));
        chk("add_wr",  32'(w),       32'(1));
        chk("add_r4",  32'(regs[4]), 32'(12));
        chk("add_zf",  32'(zero_flag), 32'(0));

        run("sub", ALU, FN_SUB, 5'd5, 5'd1, 5'd1, 8'h00, 4'd0, 1, 1);
        chk("sub_r5", 32'(regs[5]),   32'(0));
        chk("sub_zf", 32'(zero_flag), 32'(1));

        // REPEAT ADD r6 += r7, five times.
        run("ldr6", LOADI, 5'd0, 5'd6, 5'd0, 5'd0, 8'd1, 4'd0, 1, 1);
        run("ldr7", LOADI, 5'd0, 5'd7, 5'd0, 5'd0, 8'd1, 4'd0, 1, 1);
        run("rep5", REPEAT, FN_ADD, 5'd6, 5'd0, 5'd7, 8'h00, 4'd5, 5, 5);
        chk("rep5_r6", 32'(regs[6]),   32'(6));
        chk("rep5_zf", 32'(zero_flag), 32'(0));

        run("rep0", REPEAT, FN_ADD, 5'd6, 5'd0, 5'd7, 8'h00, 4'd0, 0, 0);
        chk("rep0_r6", 32'(regs[6]), 32'(6));
        run("nop", NOP, 5'd0, 5'd9, 5'd0, 5'd0, 8'h55, 4'd3, 0, 0);

        // cmd_valid held across a busy command.
        @(negedge clock);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        cmd_op = LOADI; cmd_dst = 5'd9; cmd_imm = 8'h11; cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_dst = 5'd10; cmd_imm = 8'h22;
        gap = 1;
        while (gap < 40) begin
            @(negedge clock);
            if (cmd_ready) break;
            gap++;
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        chk("b2b_gap", 32'(gap), 32'(3));
        repeat (5) @(posedge clock);
        #1;
        chk("b2b_writes", 32'(wr_cnt - wr0),   32'(2));
        chk("b2b_dones",  32'(done_cnt - dn0), 32'(2));
        chk("b2b_r9",     32'(regs[9]),  32'h11);
        chk("b2b_r10",    32'(regs[10]), 32'h22);

        // Reset during the third iteration of REPEAT count=8.
        run("ldr11", LOADI, 5'd0, 5'd11, 5'd0, 5'd0, 8'd1, 4'd0, 1, 1);
        run("ldr12", LOADI, 5'd0, 5'd12, 5'd0, 5'd0, 8'd3, 4'd0, 1, 1);
        issue(REPEAT, FN_ADD, 5'd11, 5'd0, 5'd12, 8'h00, 4'd8);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_wr_gated", 32'(RegWrite),  32'(0));
        chk("abort_ready",    32'(cmd_ready), 32'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_ready_after", 32'(cmd_ready), 32'(1));
        repeat (4) @(posedge clock);
        #1;
        chk("abort_writes", 32'(wr_cnt - wr0),   32'(2));
        chk("abort_dones",  32'(done_cnt - dn0), 32'(0));
        chk("abort_r11",    32'(regs[11]),       32'(7));
        chk("abort_zf",     32'(zero_flag),      32'(0));
        chk("abort_busy",   32'(busy),           32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle command sequencer sitting directly upstream of the register-file/ALU datapath. It accepts one command at a time over a valid/ready handshake. It drives the datapath's register addresses, ALU function, write data and write enable, and writes back either an immediate or the ALU result. It also supports an iterated in-place ALU operation (REPEAT) and reports completion and the zero flag of the last write.

## Interface
Parameters:
- Nloc, 32, number of datapath registers; address width AW = $clog2(Nloc)
- Dbits, 8, datapath word width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 NOP, 01 LOADI, 10 ALU, 11 REPEAT
- cmd_alufn  in  5  ALU function code passed to datapath
- cmd_dst  in  AW  destination register
- cmd_src1  in  AW  first source (ALU only)
- cmd_src2  in  AW  second source (ALU, REPEAT)
- cmd_imm  in  Dbits  immediate (LOADI)
- cmd_count  in  4  iteration count (REPEAT)
- RegWrite  out  1  datapath write enable
- ReadAddr1, ReadAddr2, WriteAddr  out  AW  datapath addresses
- ALUFN  out  5  datapath ALU function
- WriteData  out  Dbits  datapath write data
- ALUResult  in  Dbits  from datapath
- FlagZ  in  1  from datapath
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- zero_flag  out  1  zero status of most recent register write

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch all cmd_* fields and go to EXEC. NOP, and REPEAT with cmd_count = 0, go straight to DONE instead.
- EXEC, LOADI: RegWrite = 1, WriteAddr = dst, WriteData = imm. zero_flag <= (imm == 0). Next state DONE.
- EXEC, ALU: ReadAddr1 = src1, ReadAddr2 = src2, ALUFN = alufn, WriteAddr = dst, WriteData = ALUResult (combinational), RegWrite = 1. zero_flag <= FlagZ. Next state DONE.
- EXEC, REPEAT: ReadAddr1 = dst, ReadAddr2 = src2, WriteAddr = dst, WriteData = ALUResult, RegWrite = 1. Each cycle, the remaining counter (loaded with cmd_count) decrements and zero_flag <= FlagZ. Stay in EXEC while remaining > 1; go to DONE when remaining == 1. This gives exactly cmd_count writes of dst <= dst op src2.
- DONE: done = 1 for one cycle, then IDLE.
- busy = 1 in EXEC and DONE.
- Outside EXEC: RegWrite = 0. Address and ALUFN outputs hold their latched values; WriteData = ALUResult.
- Commands are never queued. cmd_valid seen while cmd_ready = 0 is ignored, and the driver must hold it.
- Width rules:
  - cmd_count is unsigned, 0–15.
  - Latched AW-bit addresses are used unmodified.
  - The immediate is exactly Dbits wide; no extension.

## Timing
- Reset, applied synchronously on the next edge: state IDLE, all latched fields 0, remaining = 0, zero_flag = 0, done = 0.
- While reset is high: cmd_ready = 0, RegWrite = 0, done = 0, busy = 0 (combinationally gated).
- Reset mid-EXEC aborts the command. No write occurs on that edge and no done pulse is produced.
- LOADI/ALU command accepted at edge k:
  - register write lands at edge k+1;
  - done is high during cycle k+1..k+2 (between edges k+1 and k+2);
  - cmd_ready returns high after edge k+2.
- REPEAT accepted at edge k with count N ≥ 1: writes land at edges k+1..k+N, done follows the last write, cmd_ready returns after edge k+N+1.
- NOP, or REPEAT with N = 0: no write; done is high in the cycle after acceptance.
- Back-to-back throughput: one LOADI/ALU command every 3 cycles.
- FlagZ and ALUResult are sampled in the same cycle RegWrite is asserted. This relies on the datapath's combinational read path.

## Test plan
- Reset then idle: cmd_ready = 1, RegWrite = 0, done = 0, zero_flag = 0 for 10 cycles.
- LOADI dst=3, imm=0x2A: exactly one RegWrite cycle with WriteAddr = 3 and WriteData = 0x2A. Then one done pulse; zero_flag = 0. LOADI imm=0 → zero_flag = 1.
- LOADI r1=5, LOADI r2=7, ALU ADD dst=4 src1=1 src2=2 against a behavioural regfile/ALU: r4 = 12 and zero_flag = 0. SUB r1,r1 into r5 → r5 = 0 and zero_flag = 1.
- r6=1, r7=1, REPEAT ADD dst=6 src2=7 count=5 → exactly 5 write cycles, r6 = 6, single done pulse. count=0 → no RegWrite, done the cycle after acceptance.
- cmd_valid held high across a busy command: the second command is accepted only when cmd_ready returns. No command is lost or duplicated.
- Reset asserted during the 3rd iteration of REPEAT count=8: no further writes, r-dst reflects exactly 2 iterations, no done pulse, cmd_ready = 1 after reset deasserts.
